instr_fetch: RTL and testbench



---
 rtl/rv32i_pkg.sv | 19 +
 rtl/instr_fifo.sv | 53 +++++
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, instruction alignment, reset PC
// and the fetch entry (instruction word plus its address) passed to decode.
package rv32i_pkg;

    localparam int              XLEN         = 32;
    localparam int              INSTR_ALIGN  = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Force an address onto an instruction word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO with flush. A push is accepted when not full, or when
// full but popping in the same cycle. Flush empties it and overrides push/pop.
module instr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
)(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_count   = r_cnt;
    assign o_data    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers and occupancy; depth is a power of two so pointers wrap freely.
    always_ff @(posedge Clk) begin
        if (Rst || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage; contents need no reset since reads are qualified by occupancy.
    always_ff @(posedge Clk) begin
        if (w_do_push && !Rst && !i_flush) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited word requests, tags
// returned words with their request address and queues them for decode.
// A redirect flushes both queues and drops every fetch still in flight.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int              FIFO_DEPTH = 4
)(
    input  logic            Clk,
    input  logic            Rst,
    output logic            Imem_Req_Valid,
    input  logic            Imem_Req_Ready,
    output logic [XLEN-1:0] Imem_Req_Addr,
    input  logic            Imem_Rsp_Valid,
    input  logic [XLEN-1:0] Imem_Rsp_Data,
    input  logic            PC_Sel,
    input  logic [XLEN-1:0] PC_Target,
    output logic            Instr_Valid,
    input  logic            Instr_Ready,
    output logic [XLEN-1:0] Instruction,
    output logic [XLEN-1:0] Instr_PC,
    output logic            Fetch_Misalign
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   r_drop;
    logic            r_misalign;

    logic            w_req_hs;
    logic            w_rsp;
    logic            w_rsp_keep;
    logic            w_pop;
    logic [CW-1:0]   w_out_next;
    logic [CW:0]     w_inflight;
    logic [CW-1:0]   w_ent_cnt;
    logic            w_ent_full;
    logic            w_ent_empty;
    logic [CW-1:0]   w_adr_cnt;
    logic            w_adr_full;
    logic            w_adr_empty;
    logic [XLEN-1:0] w_adr_head;
    fetch_entry_t    w_push_ent;
    fetch_entry_t    w_head;

    // Credit: in-flight requests plus queued words never exceed the queue depth,
    // so a response always finds a free slot and never needs backpressure.
    assign w_inflight     = {1'b0, r_out} + {1'b0, w_ent_cnt};
    assign Imem_Req_Valid = !Rst && (w_inflight < (CW+1)'(FIFO_DEPTH));
    assign Imem_Req_Addr  = r_pc;
    assign w_req_hs       = Imem_Req_Valid && Imem_Req_Ready;

    // Responses with nothing outstanding are protocol violations and ignored.
    assign w_rsp      = Imem_Rsp_Valid && (r_out != '0);
    assign w_rsp_keep = w_rsp && (r_drop == '0) && !PC_Sel;
    assign w_out_next = r_out + CW'(w_req_hs) - CW'(w_rsp);

    assign Instr_Valid = !w_ent_empty;
    assign w_pop       = Instr_Valid && Instr_Ready && !PC_Sel;
    assign Instruction = Instr_Valid ? w_head.instr : '0;
    assign Instr_PC    = Instr_Valid ? w_head.pc    : '0;

    assign w_push_ent.instr = Imem_Rsp_Data;
    assign w_push_ent.pc    = w_adr_head;
    assign Fetch_Misalign   = r_misalign;

    // Addresses of live (non-stale) requests, in issue order.
    instr_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_adr_q (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_push  (w_req_hs),
        .i_data  (r_pc),
        .i_pop   (w_rsp_keep),
        .i_flush (PC_Sel),
        .o_data  (w_adr_head),
        .o_count (w_adr_cnt),
        .o_full  (w_adr_full),
        .o_empty (w_adr_empty)
    );

    // Fetched words awaiting decode.
    instr_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_ent_q (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_push  (w_rsp_keep),
        .i_data  (w_push_ent),
        .i_pop   (w_pop),
        .i_flush (PC_Sel),
        .o_data  (w_head),
        .o_count (w_ent_cnt),
        .o_full  (w_ent_full),
        .o_empty (w_ent_empty)
    );

    // PC, outstanding and drop counters; a redirect overrides the sequential PC
    // and marks everything still in flight (including this cycle's request) stale.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc   <= RESET_PC;
            r_out  <= '0;
            r_drop <= '0;
        end else begin
            r_out <= w_out_next;
            if (PC_Sel) begin
                r_pc   <= align_pc(PC_Target);
                r_drop <= w_out_next;
            end else begin
                if (w_req_hs) r_pc <= r_pc + XLEN'(INSTR_ALIGN);
                if (w_rsp && (r_drop != '0)) r_drop <= r_drop - 1'b1;
            end
        end
    end

    // One-cycle pulse when a redirect target is not word aligned.
    always_ff @(posedge Clk) begin
        if (Rst) r_misalign <= 1'b0;
        else     r_misalign <= PC_Sel && (PC_Target[1:0] != 2'b00);
    end

    a_rsp_orphan: assert property (@(posedge Clk) disable iff (Rst)
        !(Imem_Rsp_Valid && (r_out == '0)))
        else $error("instr_fetch: response with no request outstanding");

    a_credit: assert property (@(posedge Clk) disable iff (Rst)
        (w_inflight <= (CW+1)'(FIFO_DEPTH)) && !(w_rsp_keep && w_ent_full && !w_pop));

    a_adr_track: assert property (@(posedge Clk) disable iff (Rst)
        (w_adr_cnt <= r_out) && !(w_rsp_keep && w_adr_empty) && !(w_req_hs && w_adr_full && !PC_Sel));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch. A latency-variable in-order memory serves
// any requested word; the reference model is the expected program order
// (sequential PCs restarting at each aligned redirect target).
module tb_instr_fetch;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Imem_Req_Valid;
    logic        Imem_Req_Ready = 1'b0;
    logic [31:0] Imem_Req_Addr;
    logic        Imem_Rsp_Valid = 1'b0;
    logic [31:0] Imem_Rsp_Data = '0;
    logic        PC_Sel = 1'b0;
    logic [31:0] PC_Target = '0;
    logic        Instr_Valid;
    logic        Instr_Ready = 1'b0;
    logic [31:0] Instruction;
    logic [31:0] Instr_PC;
    logic        Fetch_Misalign;

    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Imem_Req_Valid (Imem_Req_Valid),
        .Imem_Req_Ready (Imem_Req_Ready),
        .Imem_Req_Addr  (Imem_Req_Addr),
        .Imem_Rsp_Valid (Imem_Rsp_Valid),
        .Imem_Rsp_Data  (Imem_Rsp_Data),
        .PC_Sel         (PC_Sel),
        .PC_Target      (PC_Target),
        .Instr_Valid    (Instr_Valid),
        .Instr_Ready    (Instr_Ready),
        .Instruction    (Instruction),
        .Instr_PC       (Instr_PC),
        .Fetch_Misalign (Fetch_Misalign)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       mem_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          n_req = 0;
    int          n_out = 0;
    int          first_vld = -1;
    logic [31:0] exp_req;
    logic [31:0] exp_out;
    logic        exp_mis = 1'b0;
    logic        prev_sel = 1'b0;
    logic        last_rv;
    logic        saw_zero;

    // stimulus knobs
    int          k_req_pct = 100;
    int          k_ins_pct = 100;
    int          k_lat_min = 1;
    int          k_lat_max = 1;
    int          k_sel_pct = 0;
    logic        k_force = 1'b0;
    logic [31:0] k_tgt = '0;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Rst = 1'b1;
            Imem_Req_Ready = 1'b1;
            Imem_Rsp_Valid = 1'b0;
            PC_Sel = 1'b0;
            Instr_Ready = 1'b1;
            #1;
            if (i == n - 1) begin
                chk("rst_req_valid", 32'(Imem_Req_Valid), 0);
                chk("rst_instr_valid", 32'(Instr_Valid), 0);
                chk("rst_misalign", 32'(Fetch_Misalign), 0);
                chk("rst_instruction", Instruction, 0);
                chk("rst_instr_pc", Instr_PC, 0);
            end
            cyc++;
        end
        mem_q.delete();
        exp_req = RST_PC;
        exp_out = RST_PC;
        exp_mis = 1'b0;
        prev_sel = 1'b0;
        last_due = cyc;
    endtask

    // One clock: drive inputs after the falling edge, then check and update the model.
    task automatic step();
        int lat;
        int due;
        pend_t p;
        @(negedge Clk);
        Rst = 1'b0;
        Imem_Req_Ready = ($urandom_range(99) < k_req_pct);
        Instr_Ready    = ($urandom_range(99) < k_ins_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            p = mem_q.pop_front();
            Imem_Rsp_Valid = 1'b1;
            Imem_Rsp_Data  = mw(p.addr);
        end else begin
            Imem_Rsp_Valid = 1'b0;
            Imem_Rsp_Data  = '0;
        end
        PC_Sel = k_force || ($urandom_range(99) < k_sel_pct);
        PC_Target = k_force ? k_tgt : 32'($urandom_range(32'h3FF));
        #1;
        chk("misalign", 32'(Fetch_Misalign), 32'(exp_mis));
        if (prev_sel) chk("valid_after_sel", 32'(Instr_Valid), 0);
        if (Instr_Valid && first_vld < 0) first_vld = cyc;
        last_rv = Imem_Req_Valid;
        if (Imem_Req_Valid && Imem_Req_Ready) begin
            chk("req_addr", Imem_Req_Addr, exp_req);
            if (Imem_Req_Addr == 32'h0) saw_zero = 1'b1;
            lat = $urandom_range(k_lat_max, k_lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            p.addr = Imem_Req_Addr;
            p.due  = due;
            mem_q.push_back(p);
            exp_req = exp_req + 32'd4;
            n_req++;
        end
        if (Instr_Valid && Instr_Ready && !PC_Sel) begin
            chk("instr_pc", Instr_PC, exp_out);
            chk("instruction", Instruction, mw(exp_out));
            exp_out = exp_out + 32'd4;
            n_out++;
        end
        if (PC_Sel) begin
            exp_req = {PC_Target[31:2], 2'b00};
            exp_out = {PC_Target[31:2], 2'b00};
        end
        chk("credit", 32'(mem_q.size() <= DEPTH), 1);
        exp_mis  = PC_Sel && (PC_Target[1:0] != 2'b00);
        prev_sel = PC_Sel;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        k_req_pct = 0; k_ins_pct = 100; k_sel_pct = 0; k_force = 1'b0;
        run(14);
        chk("drained", 32'(mem_q.size()), 0);
        chk("drained_valid", 32'(Instr_Valid), 0);
    endtask

    initial begin
        int rel;
        int base;
        saw_zero = 1'b0;
        do_reset(3);

        // Streaming from reset, latency 1, decode always ready.
        rel = cyc;
        first_vld = -1;
        k_lat_min = 1; k_lat_max = 1;
        run(12);
        chk("first_valid_latency", 32'(first_vld - rel), 2);
        chk("stream_outputs", 32'(n_out >= 8), 1);

        // Decode stalled: credit allows exactly DEPTH requests.
        drain();
        k_req_pct = 100; k_ins_pct = 0;
        base = n_req;
        run(10);
        chk("stall_req_count", 32'(n_req - base), DEPTH);
        chk("stall_req_valid", 32'(last_rv), 0);
        k_ins_pct = 100;
        run(20);

        // Redirect with 3 fetches in flight.
        drain();
        k_req_pct = 100; k_lat_min = 5; k_lat_max = 5;
        run(3);
        chk("three_outstanding", 32'(mem_q.size()), 3);
        k_force = 1'b1; k_tgt = 32'h0000_0100;
        step();
        k_force = 1'b0; k_lat_min = 1; k_lat_max = 1;
        base = n_out;
        run(20);
        chk("post_redirect_outputs", 32'(n_out - base > 4), 1);

        // Misaligned target.
        k_force = 1'b1; k_tgt = 32'h0000_0102;
        step();
        k_force = 1'b0;
        run(10);

        // Redirect during steady push/pop to the top word; PC must wrap.
        saw_zero = 1'b0;
        k_force = 1'b1; k_tgt = 32'hFFFF_FFFC;
        step();
        k_force = 1'b0;
        run(10);
        chk("pc_wrap", 32'(saw_zero), 1);

        // Random traffic.
        k_req_pct = 80; k_ins_pct = 60; k_lat_min = 1; k_lat_max = 5; k_sel_pct = 3;
        run(3000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
